// File: rtl/mux_out_skid_buffer_pkg.sv
// Shared definitions for the mux output skid buffer: data width default,
// state encodings and transfer-counter width.
package mux_out_skid_buffer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/mux_out_skid_buffer_xfer_counter.sv
// Free-running wrap counter of completed output transfers; only built when
// MUX_SKID_COUNT_EN is defined.
`ifdef MUX_SKID_COUNT_EN
module xfer_counter
  import mux_out_skid_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count enabled cycles, wrapping naturally at the counter width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_en) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule
`endif

// File: rtl/mux_out_skid_buffer.sv
// Two-entry skid buffer behind the 2:1 operand mux with fully registered
// valid/ready outputs. Optional transfer counter: MUX_SKID_COUNT_EN.
module mux_out_skid_buffer
  import mux_out_skid_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef MUX_SKID_COUNT_EN
  ,
  output logic [CNT_W-1:0]  xfer_count
`endif
);

  skid_state_e       r_state;
  skid_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              w_in_xfer;
  logic              w_out_xfer;

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Next-state and storage update for the two-entry buffer.
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_main_nxt  = in_data;
          w_state_nxt = ST_ONE;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_main_nxt  = in_data;
          w_state_nxt = ST_ONE;
        end else if (w_in_xfer) begin
          w_skid_nxt  = in_data;
          w_state_nxt = ST_TWO;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_ONE;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only the drain path can fire.
        if (w_out_xfer) begin
          w_main_nxt  = r_skid;
          w_state_nxt = ST_ONE;
        end else begin
          w_state_nxt = ST_TWO;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // State, storage and registered handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main      <= {DATA_W{1'b0}};
      r_skid      <= {DATA_W{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      r_in_ready  <= (w_state_nxt != ST_TWO);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;

`ifdef MUX_SKID_COUNT_EN
  xfer_counter u_xfer_counter (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_out_xfer),
    .o_count (xfer_count)
  );
`endif

endmodule
